// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, taken-branch flush, load-use stall, jump flush.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        ex_br_taken,
    input  logic        id_jump,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        exmem_we,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        stall,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic {RUN, MEMWAIT} state_e;

    typedef enum logic [2:0] {
        ACT_NORMAL,
        ACT_FREEZE,
        ACT_BRANCH,
        ACT_LOADUSE,
        ACT_JUMP
    } act_e;

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic        lu_hold_q, lu_hold_d;

    logic        freeze;
    logic        load_use;
    act_e        act;

    // Once a load-use bubble is issued the consumer stays in ID for one more
    // cycle; lu_hold_q keeps that cycle from being counted as a second hazard.
    always_comb begin
        freeze   = mem_req && !mem_ready;
        load_use = ex_memread && (ex_rt != 5'd0) && !lu_hold_q &&
                   ((id_use_rs && (id_rs == ex_rt)) ||
                    (id_use_rt && (id_rt == ex_rt)));

        if (freeze)
            act = ACT_FREEZE;
        else if (ex_br_taken)
            act = ACT_BRANCH;
        else if (load_use)
            act = ACT_LOADUSE;
        else if (id_jump)
            act = ACT_JUMP;
        else
            act = ACT_NORMAL;
    end

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall       = 1'b0;
        unique case (act)
            ACT_FREEZE: begin
                pc_we    = 1'b0;
                ifid_we  = 1'b0;
                idex_we  = 1'b0;
                exmem_we = 1'b0;
                stall    = 1'b1;
            end
            ACT_BRANCH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            ACT_LOADUSE: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
                stall       = 1'b1;
            end
            ACT_JUMP: begin
                ifid_flush = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d    = MEMWAIT;
                    wait_cnt_d = '0;
                end
            end
            MEMWAIT: begin
                if (wait_cnt_q != 8'hFF)
                    wait_cnt_d = wait_cnt_q + 8'd1;
                if (mem_ready)
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        mem_timeout_d = mem_timeout_q || (wait_cnt_d == 8'hFF);
        lu_hold_d     = freeze ? lu_hold_q : (act == ACT_LOADUSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            lu_hold_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            lu_hold_q     <= lu_hold_d;
        end
    end

    assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (ifid_flush && (flush_cnt_q != 16'hFFFF))
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// against a priority-rule reference model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_use_rs, id_use_rt, ex_memread, ex_br_taken, id_jump, mem_req, mem_ready;
    logic        pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, stall, mem_timeout;
    logic [15:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken),
        .id_jump(id_jump), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .stall(stall),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Output vector order: {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, stall}
    localparam logic [6:0] O_FREEZE = 7'b0000001;
    localparam logic [6:0] O_BRANCH = 7'b1111110;
    localparam logic [6:0] O_LU     = 7'b0011011;
    localparam logic [6:0] O_JUMP   = 7'b1111100;
    localparam logic [6:0] O_NORMAL = 7'b1111000;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    bit m_wait, m_tmo, m_lu_prev;
    int m_wcnt, m_sc, m_fc;
    logic [6:0] last_obs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] model_out();
        bit lu;
        lu = ex_memread && (ex_rt != 0) && !m_lu_prev &&
             ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt));
        if (mem_req && !mem_ready) return O_FREEZE;
        if (ex_br_taken)           return O_BRANCH;
        if (lu)                    return O_LU;
        if (id_jump)               return O_JUMP;
        return O_NORMAL;
    endfunction

    function automatic int exp_cnt(input int v);
`ifdef HAZARD_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic mrd, input logic [4:0] ert,
                          input logic br, input logic jmp, input logic req, input logic rdy);
        id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt; ex_memread = mrd;
        ex_rt = ert; ex_br_taken = br; id_jump = jmp; mem_req = req; mem_ready = rdy;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One pipeline cycle: check outputs mid-cycle, then advance the model at the edge.
    task automatic step(input string tag);
        logic [6:0] e;
        bit freeze;
        @(negedge clk);
        e = model_out();
        last_obs = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, stall};
        check({tag, "_out"}, {25'd0, last_obs}, {25'd0, e});
        check({tag, "_tmo"}, {31'd0, mem_timeout}, {31'd0, m_tmo});
        check({tag, "_scnt"}, {16'd0, stall_cnt}, exp_cnt(m_sc));
        check({tag, "_fcnt"}, {16'd0, flush_cnt}, exp_cnt(m_fc));
        @(posedge clk);
        freeze = mem_req && !mem_ready;
        if (!m_wait) begin
            if (freeze) begin m_wait = 1; m_wcnt = 0; end
        end else begin
            if (m_wcnt < 255) m_wcnt++;
            if (mem_ready) m_wait = 0;
        end
        if (m_wcnt == 255) m_tmo = 1;
        if (!freeze) m_lu_prev = (e == O_LU);
        if (e[0] && m_sc < 16'hFFFF) m_sc++;
        if (e[2] && m_fc < 16'hFFFF) m_fc++;
        #1;
    endtask

    // Asynchronous reset asserted away from any clock edge, checked before the next edge.
    task automatic pulse_reset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        m_wait = 0; m_tmo = 0; m_lu_prev = 0; m_wcnt = 0; m_sc = 0; m_fc = 0;
        check({tag, "_tmo"}, {31'd0, mem_timeout}, 32'd0);
        check({tag, "_wcnt"}, {24'd0, dut.wait_cnt_q}, 32'd0);
        check({tag, "_scnt"}, {16'd0, stall_cnt}, 32'd0);
        check({tag, "_fcnt"}, {16'd0, flush_cnt}, 32'd0);
        check({tag, "_out"}, {25'd0, pc_we, ifid_we, idex_we, exmem_we, ifid_flush,
              idex_bubble, stall}, {25'd0, model_out()});
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        m_wait = 0; m_tmo = 0; m_lu_prev = 0; m_wcnt = 0; m_sc = 0; m_fc = 0;
        #3;
        check("rst_tmo", {31'd0, mem_timeout}, 32'd0);
        check("rst_out", {25'd0, pc_we, ifid_we, idex_we, exmem_we, ifid_flush,
              idex_bubble, stall}, {25'd0, O_NORMAL});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("idle");

        // Load-use on rs: one stall cycle then normal with the same inputs held.
        set_in(5'd8, 5'd3, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu1");
        check("lu1_const", {25'd0, last_obs}, {25'd0, O_LU});
        step("lu2");
        check("lu2_const", {25'd0, last_obs}, {25'd0, O_NORMAL});
        idle(); step("idle2");

        // Load-use on rt only.
        set_in(5'd1, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lurt");
        check("lurt_const", {25'd0, last_obs}, {25'd0, O_LU});
        idle(); step("idle3");

        // Branch beats load-use and jump.
        set_in(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        step("br");
        check("br_const", {25'd0, last_obs}, {25'd0, O_BRANCH});
        idle(); step("idle4");

        // Jump coincident with load-use: stall first, flush next.
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        step("jlu1");
        check("jlu1_const", {25'd0, last_obs}, {25'd0, O_LU});
        step("jlu2");
        check("jlu2_const", {25'd0, last_obs}, {25'd0, O_JUMP});
        idle(); step("idle5");

        // Register zero never stalls.
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("r0");
        check("r0_const", {25'd0, last_obs}, {25'd0, O_NORMAL});

        // Statistics: 3 load-use stalls and 2 jumps from a clean reset.
        pulse_reset("rst_a");
        for (int i = 0; i < 3; i++) begin
            set_in(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
            step("st_lu");
            idle(); step("st_gap");
        end
        for (int i = 0; i < 2; i++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            step("st_j");
        end
        idle();
        @(negedge clk);
        check("stall_cnt3", {16'd0, stall_cnt}, exp_cnt(3));
        check("flush_cnt2", {16'd0, flush_cnt}, exp_cnt(2));
        @(posedge clk); #1;

        // Three-cycle memory wait, released on the fourth.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("mw");
            check("mw_const", {25'd0, last_obs}, {25'd0, O_FREEZE});
        end
        mem_ready = 1'b1;
        step("mw_rel");
        check("mw_rel_const", {25'd0, last_obs}, {25'd0, O_NORMAL});
        check("mw_tmo", {31'd0, mem_timeout}, 32'd0);
        idle(); step("mw_after");

        // Randomized traffic with small register ranges so hazards collide often.
        for (int i = 0; i < 400; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                   1'($urandom));
            step("rnd");
        end

        // Long wait: timeout must assert exactly when the model says and stick.
        pulse_reset("rst_b");
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) step("long");
        check("long_wcnt", {24'd0, dut.wait_cnt_q}, 32'd255);
        check("long_tmo", {31'd0, mem_timeout}, 32'd1);
        pulse_reset("rst_c");
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("post_rst");
        check("post_rst_const", {25'd0, last_obs}, {25'd0, O_NORMAL});
        idle(); step("post_rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
